// File: rtl/uart_echo_fifo_if.sv
// Host-side handshake bundle for uart_echo_fifo: RX FIFO head out, TX byte in.
// The DUT uses the slave view; a host or bench uses master.
interface uart_echo_fifo_if #(parameter int DATA_BITS = 8);
   logic                 rx_valid;
   logic                 rx_ready;
   logic [DATA_BITS-1:0] rx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [DATA_BITS-1:0] tx_data;

   modport master (input rx_valid, rx_data, tx_ready, output rx_ready, tx_valid, tx_data);
   modport slave  (output rx_valid, rx_data, tx_ready, input rx_ready, tx_valid, tx_data);
endinterface

// File: rtl/uart_echo_fifo.sv
// Parametrised UART RX/TX with an RX FIFO that either echoes into TX or feeds a
// host over valid/ready; status LEDs and per-frame error pulses.
module uart_echo_fifo #(
   parameter int CLK_FREQ  = 50000000,
   parameter int UART_BPS  = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int FIFO_AW   = 4
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               uart_rxd,
   output logic               uart_txd,
   input  logic               echo_en,
   uart_echo_fifo_if.slave    bus,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               rx_done,
   output logic               frame_err,
   output logic               parity_err,
   output logic               overflow,
   output logic [3:0]         led_en
);
   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int CW      = $clog2(BPS_CNT);
   localparam int IW      = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_MAX   = CW'(BPS_CNT - 1);
   localparam logic [CW-1:0] CNT_MID   = CW'(BPS_CNT / 2);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_PAR   = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;

   function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
      return (PARITY == 1) ? ~(^d) : (^d);
   endfunction

   logic rxd_meta_r, rxd_sync_r, rxd_prev_r;
   logic [2:0]           rx_state_r, tx_state_r;
   logic [CW-1:0]        rx_cnt_r, tx_cnt_r;
   logic [IW-1:0]        rx_idx_r, tx_idx_r;
   logic [DATA_BITS-1:0] rx_shift_r, tx_shift_r;
   logic rx_perr_r, rx_ferr_r, rx_stop_r, tx_stop_r, tx_par_r;
   logic tx_armed_r, tx_busy_r, rx_tog_r, err_sticky_r, ovf_sticky_r;
   logic [FIFO_AW:0]     wr_ptr_r, rd_ptr_r;
   logic [DATA_BITS-1:0] mem_r [2**FIFO_AW];

   logic rx_fall_s, last_stop_s, ferr_s, perr_s, good_s, empty_s, full_s;
   logic tx_idle_s, echo_pop_s, host_rd_s, host_acc_s, rd_en_s, wr_en_s, ovf_s;
   logic [DATA_BITS-1:0] head_s;

   // Frame disposition, FIFO flags and the single read strobe shared by both modes.
   always_comb begin
      rx_fall_s   = (rx_state_r == ST_IDLE) & rxd_prev_r & ~rxd_sync_r;
      last_stop_s = (rx_state_r == ST_STOP) & (rx_cnt_r == CNT_MID) & (rx_stop_r == STOP_LAST);
      ferr_s      = last_stop_s & (rx_ferr_r | ~rxd_sync_r);
      perr_s      = last_stop_s & ~(rx_ferr_r | ~rxd_sync_r) & rx_perr_r;
      good_s      = last_stop_s & ~(rx_ferr_r | ~rxd_sync_r) & ~rx_perr_r;
      empty_s     = (wr_ptr_r == rd_ptr_r);
      full_s      = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                    (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
      head_s      = mem_r[rd_ptr_r[FIFO_AW-1:0]];
      tx_idle_s   = tx_armed_r & (tx_state_r == ST_IDLE);
      echo_pop_s  = echo_en & tx_idle_s & ~empty_s;
      host_rd_s   = ~echo_en & ~empty_s & bus.rx_ready;
      host_acc_s  = ~echo_en & tx_idle_s & bus.tx_valid;
      rd_en_s     = echo_pop_s | host_rd_s;
      // a full FIFO still takes the write when the head leaves in the same cycle
      wr_en_s     = good_s & (~full_s | rd_en_s);
      ovf_s       = good_s & full_s & ~rd_en_s;
   end

   assign bus.rx_valid = ~empty_s & ~echo_en;
   assign bus.rx_data  = empty_s ? {DATA_BITS{1'b0}} : head_s;
   assign bus.tx_ready = tx_idle_s & ~echo_en;
   assign led_en       = {ovf_sticky_r, err_sticky_r, tx_busy_r, rx_tog_r};

   // Two-flop synchroniser plus history flop for the start-edge detector.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rxd_meta_r <= 1'b1;
         rxd_sync_r <= 1'b1;
         rxd_prev_r <= 1'b1;
      end else begin
         rxd_meta_r <= uart_rxd;
         rxd_sync_r <= rxd_meta_r;
         rxd_prev_r <= rxd_sync_r;
      end
   end

   // RX frame FSM: mid-bit sampling, returns to IDLE at the last stop mid-sample.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_state_r <= ST_IDLE;
         rx_cnt_r   <= '0;
         rx_idx_r   <= '0;
         rx_shift_r <= '0;
         rx_perr_r  <= 1'b0;
         rx_ferr_r  <= 1'b0;
         rx_stop_r  <= 1'b0;
      end else begin
         case (rx_state_r)
            ST_IDLE: begin
               if (rx_fall_s) begin
                  rx_state_r <= ST_START;
                  rx_cnt_r   <= '0;
                  rx_perr_r  <= 1'b0;
                  rx_ferr_r  <= 1'b0;
               end
            end
            ST_START: begin
               rx_cnt_r <= rx_cnt_r + 1'b1;
               if (rx_cnt_r == CNT_MID && rxd_sync_r) begin
                  rx_state_r <= ST_IDLE;
               end else if (rx_cnt_r == CNT_MAX) begin
                  rx_cnt_r   <= '0;
                  rx_idx_r   <= '0;
                  rx_state_r <= ST_DATA;
               end
            end
            ST_DATA: begin
               rx_cnt_r <= rx_cnt_r + 1'b1;
               if (rx_cnt_r == CNT_MID) begin
                  rx_shift_r <= {rxd_sync_r, rx_shift_r[DATA_BITS-1:1]};
               end
               if (rx_cnt_r == CNT_MAX) begin
                  rx_cnt_r <= '0;
                  if (rx_idx_r == IDX_MAX) begin
                     rx_state_r <= (PARITY != 0) ? ST_PAR : ST_STOP;
                     rx_stop_r  <= 1'b0;
                  end else begin
                     rx_idx_r <= rx_idx_r + 1'b1;
                  end
               end
            end
            ST_PAR: begin
               rx_cnt_r <= rx_cnt_r + 1'b1;
               if (rx_cnt_r == CNT_MID) begin
                  rx_perr_r <= rxd_sync_r ^ par_bit(rx_shift_r);
               end
               if (rx_cnt_r == CNT_MAX) begin
                  rx_cnt_r   <= '0;
                  rx_stop_r  <= 1'b0;
                  rx_state_r <= ST_STOP;
               end
            end
            ST_STOP: begin
               rx_cnt_r <= rx_cnt_r + 1'b1;
               if (rx_cnt_r == CNT_MID) begin
                  if (!rxd_sync_r) rx_ferr_r <= 1'b1;
                  if (rx_stop_r == STOP_LAST) rx_state_r <= ST_IDLE;
               end else if (rx_cnt_r == CNT_MAX) begin
                  rx_cnt_r  <= '0;
                  rx_stop_r <= 1'b1;
               end
            end
            default: rx_state_r <= ST_IDLE;
         endcase
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge sys_clk) begin
      if (wr_en_s) mem_r[wr_ptr_r[FIFO_AW-1:0]] <= rx_shift_r;
   end

   // FIFO pointers, occupancy, pulses and sticky status.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         fifo_level   <= '0;
         rx_done      <= 1'b0;
         frame_err    <= 1'b0;
         parity_err   <= 1'b0;
         overflow     <= 1'b0;
         rx_tog_r     <= 1'b0;
         err_sticky_r <= 1'b0;
         ovf_sticky_r <= 1'b0;
      end else begin
         if (wr_en_s) wr_ptr_r <= wr_ptr_r + 1'b1;
         if (rd_en_s) rd_ptr_r <= rd_ptr_r + 1'b1;
         case ({wr_en_s, rd_en_s})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         rx_done      <= wr_en_s;
         frame_err    <= ferr_s;
         parity_err   <= perr_s;
         overflow     <= ovf_s;
         rx_tog_r     <= rx_tog_r ^ wr_en_s;
         err_sticky_r <= err_sticky_r | ferr_s | perr_s;
         ovf_sticky_r <= ovf_sticky_r | ovf_s;
      end
   end

   // TX FSM: each bit held BPS_CNT cycles; stop end lands in IDLE for at least one cycle.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tx_state_r <= ST_IDLE;
         tx_cnt_r   <= '0;
         tx_idx_r   <= '0;
         tx_shift_r <= '0;
         tx_par_r   <= 1'b0;
         tx_stop_r  <= 1'b0;
         tx_armed_r <= 1'b0;
         tx_busy_r  <= 1'b0;
         uart_txd   <= 1'b1;
      end else begin
         tx_armed_r <= 1'b1;
         case (tx_state_r)
            ST_IDLE: begin
               if (echo_pop_s || host_acc_s) begin
                  tx_shift_r <= echo_pop_s ? head_s : bus.tx_data;
                  tx_par_r   <= par_bit(echo_pop_s ? head_s : bus.tx_data);
                  tx_cnt_r   <= '0;
                  tx_state_r <= ST_START;
                  tx_busy_r  <= 1'b1;
                  uart_txd   <= 1'b0;
               end
            end
            ST_START: begin
               tx_cnt_r <= tx_cnt_r + 1'b1;
               if (tx_cnt_r == CNT_MAX) begin
                  tx_cnt_r   <= '0;
                  tx_idx_r   <= '0;
                  tx_state_r <= ST_DATA;
                  uart_txd   <= tx_shift_r[0];
               end
            end
            ST_DATA: begin
               tx_cnt_r <= tx_cnt_r + 1'b1;
               if (tx_cnt_r == CNT_MAX) begin
                  tx_cnt_r <= '0;
                  if (tx_idx_r == IDX_MAX) begin
                     tx_stop_r  <= 1'b0;
                     tx_state_r <= (PARITY != 0) ? ST_PAR : ST_STOP;
                     uart_txd   <= (PARITY != 0) ? tx_par_r : 1'b1;
                  end else begin
                     tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
                     tx_idx_r   <= tx_idx_r + 1'b1;
                     uart_txd   <= tx_shift_r[1];
                  end
               end
            end
            ST_PAR: begin
               tx_cnt_r <= tx_cnt_r + 1'b1;
               if (tx_cnt_r == CNT_MAX) begin
                  tx_cnt_r   <= '0;
                  tx_stop_r  <= 1'b0;
                  tx_state_r <= ST_STOP;
                  uart_txd   <= 1'b1;
               end
            end
            ST_STOP: begin
               tx_cnt_r <= tx_cnt_r + 1'b1;
               if (tx_cnt_r == CNT_MAX) begin
                  tx_cnt_r <= '0;
                  if (tx_stop_r == STOP_LAST) begin
                     tx_state_r <= ST_IDLE;
                     tx_busy_r  <= 1'b0;
                  end else begin
                     tx_stop_r <= 1'b1;
                  end
               end
            end
            default: begin
               tx_state_r <= ST_IDLE;
               tx_busy_r  <= 1'b0;
               uart_txd   <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed self-checking bench for uart_echo_fifo at BPS_CNT=16, 8E1, 4-deep FIFO.
module tb_uart_echo_fifo;
   localparam int BPS = 16;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n, uart_rxd, uart_txd, echo_en;
   logic [2:0] fifo_level;
   logic       rx_done, frame_err, parity_err, overflow;
   logic [3:0] led_en;
   int n_checks = 0, n_fail = 0;
   int n_done = 0, n_ferr = 0, n_perr = 0, n_ovf = 0;

   uart_echo_fifo_if #(.DATA_BITS(8)) bus ();

   uart_echo_fifo #(.CLK_FREQ(1600), .UART_BPS(100), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .FIFO_AW(2)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
      .echo_en(echo_en), .bus(bus), .fifo_level(fifo_level), .rx_done(rx_done),
      .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow), .led_en(led_en));

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (rx_done === 1'b1)    n_done <= n_done + 1;
      if (frame_err === 1'b1)  n_ferr <= n_ferr + 1;
      if (parity_err === 1'b1) n_perr <= n_perr + 1;
      if (overflow === 1'b1)   n_ovf  <= n_ovf + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      logic [10:0] f;
      f = {s, p, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         uart_rxd = f[i];
         repeat (BPS) tick();
      end
      uart_rxd = 1'b1;
      repeat (6) tick();
   endtask

   // Waits for a start bit, samples mid-bit, counts busy cycles of the frame.
   task automatic capture_tx(output logic [10:0] bits, output int len);
      int w, k;
      w = 0;
      bits = 'x;
      while (uart_txd !== 1'b0 && w < 400) begin
         tick();
         w++;
      end
      k = 0;
      while (led_en[1] === 1'b1 && k < 400) begin
         if (k % BPS == BPS / 2 && k / BPS < 11) bits[k / BPS] = uart_txd;
         tick();
         k++;
      end
      len = k;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0; uart_rxd = 1'b1; echo_en = 1'b0;
      bus.rx_ready = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
      repeat (3) tick();
      n_checks++;
      if ({uart_txd, bus.rx_valid, bus.tx_ready} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_ctrl: got txd/rx_valid/tx_ready=%b expected 100", {uart_txd, bus.rx_valid, bus.tx_ready});
      end
      n_checks++;
      if ({fifo_level, led_en, rx_done, frame_err, parity_err, overflow} !== 11'h000 || bus.rx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_status: got level=%h led=%h pulses=%b rx_data=%h expected all 0", fifo_level, led_en,
                  {rx_done, frame_err, parity_err, overflow}, bus.rx_data);
      end
      sys_rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_echo();
      int d0, len;
      logic [10:0] bits, exp;
      exp = {1'b1, 1'b0, 8'hA5, 1'b0};
      echo_en = 1'b1;
      d0 = n_done;
      fork
         send_frame(8'hA5, 1'b0, 1'b1);
         capture_tx(bits, len);
      join
      n_checks++;
      if (n_done - d0 !== 1) begin n_fail++; $display("FAIL echo_rx_done: got %0d expected 1", n_done - d0); end
      n_checks++;
      if (bits !== exp) begin n_fail++; $display("FAIL echo_tx_bits: got %b expected %b", bits, exp); end
      n_checks++;
      if (len !== 176) begin n_fail++; $display("FAIL echo_frame_len: got %0d expected 176", len); end
      n_checks++;
      if (fifo_level !== 3'd0 || led_en[0] !== 1'b1) begin
         n_fail++; $display("FAIL echo_after: got level=%0d led0=%b expected 0,1", fifo_level, led_en[0]);
      end
      echo_en = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_host_rx();
      int d0;
      d0 = n_done;
      bus.rx_ready = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b1);
      n_checks++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h3C || fifo_level !== 3'd1) begin
         n_fail++;
         $display("FAIL host_rx_head: got valid=%b data=%h level=%0d expected 1,3c,1", bus.rx_valid, bus.rx_data, fifo_level);
      end
      n_checks++;
      if (n_done - d0 !== 1 || led_en[0] !== 1'b0) begin
         n_fail++; $display("FAIL host_rx_done: got done=%0d led0=%b expected 1,0", n_done - d0, led_en[0]);
      end
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
      n_checks++;
      if (bus.rx_valid !== 1'b0 || fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL host_rx_pop: got valid=%b level=%0d expected 0,0", bus.rx_valid, fifo_level);
      end
   endtask

   task automatic test_errors();
      int d0, f0, p0, o0;
      d0 = n_done; f0 = n_ferr; p0 = n_perr;
      send_frame(8'h01, 1'b0, 1'b1);
      n_checks++;
      if (n_perr - p0 !== 1 || n_ferr - f0 !== 0 || n_done - d0 !== 0 || fifo_level !== 3'd0 || led_en[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL parity_err: got perr=%0d ferr=%0d done=%0d level=%0d led2=%b expected 1,0,0,0,1",
                  n_perr - p0, n_ferr - f0, n_done - d0, fifo_level, led_en[2]);
      end
      f0 = n_ferr; p0 = n_perr;
      send_frame(8'h01, 1'b0, 1'b0);
      n_checks++;
      if (n_ferr - f0 !== 1 || n_perr - p0 !== 0 || n_done - d0 !== 0 || fifo_level !== 3'd0) begin
         n_fail++;
         $display("FAIL frame_err: got ferr=%0d perr=%0d done=%0d level=%0d expected 1,0,0,0",
                  n_ferr - f0, n_perr - p0, n_done - d0, fifo_level);
      end
      f0 = n_ferr; p0 = n_perr; o0 = n_ovf;
      uart_rxd = 1'b0;
      repeat (4) tick();
      uart_rxd = 1'b1;
      repeat (40) tick();
      n_checks++;
      if ((n_ferr - f0) + (n_perr - p0) + (n_ovf - o0) + (n_done - d0) !== 0 || fifo_level !== 3'd0 || led_en[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL false_start: got pulses=%0d level=%0d led3=%b expected 0,0,0",
                  (n_ferr - f0) + (n_perr - p0) + (n_ovf - o0) + (n_done - d0), fifo_level, led_en[3]);
      end
   endtask

   task automatic test_overflow();
      int d0, o0;
      logic [7:0] vals [5];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      d0 = n_done; o0 = n_ovf;
      for (int i = 0; i < 5; i++) send_frame(vals[i], 1'b0, 1'b1);
      n_checks++;
      if (fifo_level !== 3'd4 || n_done - d0 !== 4 || n_ovf - o0 !== 1) begin
         n_fail++;
         $display("FAIL overflow_count: got level=%0d done=%0d ovf=%0d expected 4,4,1", fifo_level, n_done - d0, n_ovf - o0);
      end
      n_checks++;
      if (led_en[3] !== 1'b1 || bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h11) begin
         n_fail++;
         $display("FAIL overflow_head: got led3=%b valid=%b data=%h expected 1,1,11", led_en[3], bus.rx_valid, bus.rx_data);
      end
   endtask

   task automatic test_host_tx();
      int len;
      logic [10:0] bits, exp;
      exp = {1'b1, 1'b0, 8'h0F, 1'b0};
      n_checks++;
      if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_idle: got %b expected 1", bus.tx_ready); end
      bus.tx_data = 8'h0F;
      bus.tx_valid = 1'b1;
      tick();
      n_checks++;
      if (bus.tx_ready !== 1'b0 || uart_txd !== 1'b0) begin
         n_fail++; $display("FAIL tx_accept: got tx_ready=%b txd=%b expected 0,0", bus.tx_ready, uart_txd);
      end
      bus.tx_data = 8'h30;
      capture_tx(bits, len);
      n_checks++;
      if (bits !== exp || len !== 176) begin
         n_fail++; $display("FAIL host_tx_frame: got bits=%b len=%0d expected %b,176", bits, len, exp);
      end
      n_checks++;
      if (bus.tx_ready !== 1'b1 || uart_txd !== 1'b1) begin
         n_fail++; $display("FAIL tx_idle_gap: got tx_ready=%b txd=%b expected 1,1", bus.tx_ready, uart_txd);
      end
      tick();
      bus.tx_valid = 1'b0;
      n_checks++;
      if (led_en[1] !== 1'b1 || uart_txd !== 1'b0) begin
         n_fail++; $display("FAIL tx_back_to_back: got busy=%b txd=%b expected 1,0", led_en[1], uart_txd);
      end
   endtask

   task automatic test_reset_mid_frame();
      int d0;
      repeat (4 * BPS + BPS / 2) tick();
      n_checks++;
      if (uart_txd !== 1'b0 || fifo_level !== 3'd4) begin
         n_fail++; $display("FAIL pre_reset: got txd=%b level=%0d expected 0,4", uart_txd, fifo_level);
      end
      sys_rst_n = 1'b0;
      #1;
      n_checks++;
      if (uart_txd !== 1'b1 || fifo_level !== 3'd0 || led_en !== 4'h0) begin
         n_fail++; $display("FAIL async_reset: got txd=%b level=%0d led=%h expected 1,0,0", uart_txd, fifo_level, led_en);
      end
      repeat (3) tick();
      sys_rst_n = 1'b1;
      tick();
      d0 = n_done;
      send_frame(8'h5A, 1'b0, 1'b1);
      n_checks++;
      if (n_done - d0 !== 1 || bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h5A || fifo_level !== 3'd1) begin
         n_fail++;
         $display("FAIL post_reset_rx: got done=%0d valid=%b data=%h level=%0d expected 1,1,5a,1",
                  n_done - d0, bus.rx_valid, bus.rx_data, fifo_level);
      end
   endtask

   initial begin
      test_reset();
      test_echo();
      test_host_rx();
      test_errors();
      test_overflow();
      test_host_tx();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
- Parametrised UART transceiver with an RX FIFO and selectable echo path; the next generation of the fixed 8N1 recv/send/LED top.
- Configurable data width, parity and stop bits. Received characters are buffered in a FIFO.
- Characters are either echoed automatically to TX (echo_en=1) or handed to a host over valid/ready, with TX fed by the host.
- Drives four status LEDs and reports error pulses.

Parameters:
- CLK_FREQ, 50000000: system clock in Hz.
- UART_BPS, 115200: baud rate. BPS_CNT = CLK_FREQ/UART_BPS, integer division, must be >= 8.
- DATA_BITS, 8: data bits per frame. Legal values are 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_AW, 4: FIFO address width. Depth is 2**FIFO_AW.

Ports:
- sys_clk  in  1  system clock, all logic on its rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- uart_rxd  in  1  serial input, asynchronous to sys_clk.
- uart_txd  out  1  serial output.
- echo_en  in  1  1 = FIFO drains into TX; 0 = host mode.
- rx_valid  out  1  FIFO head available to host. Forced 0 when echo_en=1.
- rx_ready  in  1  host accepts head. Ignored when echo_en=1.
- rx_data  out  DATA_BITS  FIFO head, first-word fall-through.
- tx_valid  in  1  host byte offered. Ignored when echo_en=1.
- tx_ready  out  1  TX idle and echo_en=0.
- tx_data  in  DATA_BITS  host byte.
- fifo_level  out  FIFO_AW+1  current occupancy, 0..2**FIFO_AW.
- rx_done  out  1  one-cycle pulse when a good frame is written.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- parity_err  out  1  one-cycle pulse on a parity mismatch.
- overflow  out  1  one-cycle pulse when a good frame is dropped because the FIFO is full.
- led_en  out  4  status LEDs: [0] toggles per rx_done; [1] TX busy; [2] sticky frame/parity error; [3] sticky overflow.

Behaviour:
- Reset values: uart_txd=1; every pulse output, led_en, fifo_level, rx_valid and tx_ready are 0; rx_data=0. Synchroniser flops reset to 1.
- RX front end: 2-flop synchroniser, then a falling-edge detector that is active in IDLE only.
- RX FSM states: IDLE, START, DATA, PAR, STOP.
  - Bit counter counts 0..BPS_CNT-1 and samples at BPS_CNT/2.
  - START: a sample of 1 is a false start; return to IDLE with no outputs.
  - DATA: shift in DATA_BITS bits, LSB first.
  - PAR: skipped when PARITY=0. Compare the sample against the XOR of the data, inverted for odd parity.
  - STOP: sample each of STOP_BITS stop bits; any 0 sets the frame error.
  - At the final stop-bit mid-sample, go to IDLE immediately, which allows resync to the next start edge.
- Frame disposition, decided on the cycle after the final stop sample:
  - frame error: pulse frame_err, drop the frame.
  - else parity error: pulse parity_err, drop the frame.
  - else FIFO full: pulse overflow, drop the frame.
  - else write, pulse rx_done, toggle led_en[0].
  - frame_err takes precedence over parity_err; only one pulse per frame.
- FIFO:
  - Circular buffer with FIFO_AW+1-bit pointers. Full when the pointer MSBs differ and the rest are equal.
  - Write and read in the same cycle: permitted when not empty; level unchanged. A write to a full FIFO with a simultaneous read succeeds.
  - Read when empty: ignored.
- Read source:
  - echo_en=0: read on rx_valid & rx_ready.
  - echo_en=1: internal read when TX is IDLE and the FIFO is not empty.
- TX FSM states: IDLE, START, DATA, PAR, STOP. Each bit lasts exactly BPS_CNT cycles; LSB first; parity rule as RX.
  - Acceptance occurs in IDLE only: a host handshake or an echo FIFO pop.
  - uart_txd goes low on the cycle after acceptance.
  - After the last stop-bit cycle, TX spends at least one IDLE cycle before the next start.
  - led_en[1] = 1 in any state other than IDLE.
- echo_en is sampled only at TX IDLE acceptance. Toggling it mid-frame does not disturb the current frame.
- Sticky bits led_en[2] and led_en[3] clear only on reset.
- Reset mid-frame: both FSMs return to IDLE at once, the FIFO empties, and uart_txd returns to 1 asynchronously.

Test Plan:
Bench parameters: CLK_FREQ=1600, UART_BPS=100 (BPS_CNT=16), DATA_BITS=8, PARITY=2, STOP_BITS=1, FIFO_AW=2.
- Echo: echo_en=1, send 0xA5 with even parity bit 0 -> one rx_done pulse; then uart_txd emits start, 1,0,1,0,0,1,0,1, parity 0, stop, each 16 cycles; fifo_level returns to 0.
- Host mode: echo_en=0, rx_ready=0, send 0x3C -> rx_valid=1, rx_data=0x3C, fifo_level=1. Pulse rx_ready for 1 cycle -> rx_valid=0.
- Overflow: echo_en=0, rx_ready=0, send 5 good frames -> fifo_level=4, one overflow pulse, led_en[3]=1; head still holds the first byte.
- Errors:
  - Send 0x01 with parity bit 0 -> parity_err pulse, no write, led_en[2]=1.
  - Send a frame with stop=0 -> frame_err only.
  - Hold uart_rxd low for 4 cycles -> false start, no pulses.
- Host TX: echo_en=0, tx_valid with 0x0F -> tx_ready drops, uart_txd low on the next cycle, total frame 176 cycles. tx_valid is held for a back-to-back byte, which is accepted after one IDLE cycle.
- Reset mid-frame: assert sys_rst_n=0 during TX data bit 3 -> uart_txd=1 and fifo_level=0 immediately. After release, the next frame is received correctly.
